// File: rtl/onchip_mem_arbiter.sv
// Two-master Avalon-MM arbiter in front of a single-port on-chip RAM with 1-cycle read latency.
// Build option: define ONCHIP_ARB_FIXED_PRIO_EN to make master 0 win every contended cycle.
`default_nettype none

module onchip_mem_arbiter #(
  parameter int ADDR_W    = 16,
  parameter int DATA_W    = 32,
  parameter int MEM_WORDS = 40000,
  parameter int MAX_GRANT = 2
) (
  input  logic                  clk,
  input  logic                  reset_n,

  input  logic [ADDR_W-1:0]     m0_address,
  input  logic [DATA_W/8-1:0]   m0_byteenable,
  input  logic                  m0_read,
  input  logic                  m0_write,
  input  logic [DATA_W-1:0]     m0_writedata,
  output logic                  m0_waitrequest,
  output logic [DATA_W-1:0]     m0_readdata,
  output logic                  m0_readdatavalid,

  input  logic [ADDR_W-1:0]     m1_address,
  input  logic [DATA_W/8-1:0]   m1_byteenable,
  input  logic                  m1_read,
  input  logic                  m1_write,
  input  logic [DATA_W-1:0]     m1_writedata,
  output logic                  m1_waitrequest,
  output logic [DATA_W-1:0]     m1_readdata,
  output logic                  m1_readdatavalid,

  output logic [ADDR_W-1:0]     mem_address,
  output logic [DATA_W/8-1:0]   mem_byteenable,
  output logic                  mem_chipselect,
  output logic                  mem_write,
  output logic [DATA_W-1:0]     mem_writedata,
  output logic                  mem_clken,
  input  logic [DATA_W-1:0]     mem_readdata
);

  localparam int                BE_W      = DATA_W / 8;
  localparam int                CNT_W     = $clog2(MAX_GRANT + 1);
  localparam logic [CNT_W-1:0]  CNT_MAX   = CNT_W'(MAX_GRANT);
  localparam logic [31:0]       MEM_LIMIT = 32'(MEM_WORDS);

  logic              owner_q, owner_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              rd_pend_q, rd_pend_d;
  logic              rd_owner_q, rd_owner_d;
  logic              rd_oob_q, rd_oob_d;
  logic [DATA_W-1:0] rdata0_q, rdata0_d;
  logic [DATA_W-1:0] rdata1_q, rdata1_d;

  logic              req0, req1;
  logic              gnt_vld;
  logic              gnt_sel;
  logic              acc;
  logic [ADDR_W-1:0] gnt_addr;
  logic [BE_W-1:0]   gnt_be;
  logic [DATA_W-1:0] gnt_wdata;
  logic              gnt_wr;
  logic              gnt_rd;
  logic              in_range;
  logic              rdv0, rdv1;
  logic [DATA_W-1:0] rdata_ret;

  // Grant selection: gnt_sel = 0 picks master 0, 1 picks master 1.
  always_comb begin
    req0    = m0_read | m0_write;
    req1    = m1_read | m1_write;
    gnt_vld = req0 | req1;
    gnt_sel = 1'b0;
    if (req0 && req1) begin
`ifdef ONCHIP_ARB_FIXED_PRIO_EN
      gnt_sel = 1'b0;
`else
      gnt_sel = (count_q < CNT_MAX) ? owner_q : ~owner_q;
`endif
    end else if (req1) begin
      gnt_sel = 1'b1;
    end
  end

  always_comb begin
    gnt_addr  = gnt_sel ? m1_address    : m0_address;
    gnt_be    = gnt_sel ? m1_byteenable : m0_byteenable;
    gnt_wdata = gnt_sel ? m1_writedata  : m0_writedata;
    gnt_wr    = gnt_sel ? m1_write      : m0_write;
    gnt_rd    = gnt_sel ? m1_read       : m0_read;
    in_range  = 32'(gnt_addr) < MEM_LIMIT;
    acc       = reset_n & gnt_vld;
  end

  // Out-of-range commands are still accepted; they just never reach the RAM.
  always_comb begin
    m0_waitrequest = ~(acc & ~gnt_sel);
    m1_waitrequest = ~(acc & gnt_sel);
    mem_address    = gnt_addr;
    mem_byteenable = gnt_be;
    mem_writedata  = gnt_wdata;
    mem_chipselect = acc & in_range;
    mem_write      = acc & in_range & gnt_wr;
    mem_clken      = reset_n;
  end

  always_comb begin
    owner_d = owner_q;
    count_d = count_q;
    if (gnt_vld) begin
      if (gnt_sel == owner_q) begin
        count_d = (count_q == CNT_MAX) ? count_q : count_q + CNT_W'(1);
      end else begin
        owner_d = gnt_sel;
        count_d = CNT_W'(1);
      end
    end
  end

  // A command with both read and write set is a write and returns nothing.
  always_comb begin
    rd_pend_d  = acc & gnt_rd & ~gnt_wr;
    rd_owner_d = rd_pend_d ? gnt_sel   : rd_owner_q;
    rd_oob_d   = rd_pend_d ? ~in_range : rd_oob_q;
  end

  // Return data passes straight through on its valid cycle and is held afterwards.
  always_comb begin
    rdv0             = rd_pend_q & ~rd_owner_q;
    rdv1             = rd_pend_q & rd_owner_q;
    rdata_ret        = rd_oob_q ? '0 : mem_readdata;
    m0_readdatavalid = rdv0;
    m1_readdatavalid = rdv1;
    m0_readdata      = rdv0 ? rdata_ret : rdata0_q;
    m1_readdata      = rdv1 ? rdata_ret : rdata1_q;
    rdata0_d         = m0_readdata;
    rdata1_d         = m1_readdata;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      owner_q    <= 1'b1;
      count_q    <= CNT_MAX;
      rd_pend_q  <= 1'b0;
      rd_owner_q <= 1'b0;
      rd_oob_q   <= 1'b0;
      rdata0_q   <= '0;
      rdata1_q   <= '0;
    end else begin
      owner_q    <= owner_d;
      count_q    <= count_d;
      rd_pend_q  <= rd_pend_d;
      rd_owner_q <= rd_owner_d;
      rd_oob_q   <= rd_oob_d;
      rdata0_q   <= rdata0_d;
      rdata1_q   <= rdata1_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_onchip_mem_arbiter.sv
// Directed bench for onchip_mem_arbiter with a behavioural 1-cycle-latency RAM.
`timescale 1ns/1ps

module tb_onchip_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [15:0] m0_address, m1_address;
  logic [3:0]  m0_byteenable, m1_byteenable;
  logic        m0_read, m0_write, m1_read, m1_write;
  logic [31:0] m0_writedata, m1_writedata;
  logic        m0_waitrequest, m1_waitrequest;
  logic [31:0] m0_readdata, m1_readdata;
  logic        m0_readdatavalid, m1_readdatavalid;
  logic [15:0] mem_address;
  logic [3:0]  mem_byteenable;
  logic        mem_chipselect, mem_write, mem_clken;
  logic [31:0] mem_writedata;
  logic [31:0] mem_readdata = 32'hCAFEF00D;

  logic [31:0] ram [0:65535];
  logic [31:0] ram_tmp;

  int total  = 0;
  int passed = 0;
  int fails  = 0;
  int g [6];

  always #5 clk = ~clk;

  onchip_mem_arbiter dut (
    .clk(clk), .reset_n(reset_n),
    .m0_address(m0_address), .m0_byteenable(m0_byteenable), .m0_read(m0_read),
    .m0_write(m0_write), .m0_writedata(m0_writedata), .m0_waitrequest(m0_waitrequest),
    .m0_readdata(m0_readdata), .m0_readdatavalid(m0_readdatavalid),
    .m1_address(m1_address), .m1_byteenable(m1_byteenable), .m1_read(m1_read),
    .m1_write(m1_write), .m1_writedata(m1_writedata), .m1_waitrequest(m1_waitrequest),
    .m1_readdata(m1_readdata), .m1_readdatavalid(m1_readdatavalid),
    .mem_address(mem_address), .mem_byteenable(mem_byteenable),
    .mem_chipselect(mem_chipselect), .mem_write(mem_write), .mem_writedata(mem_writedata),
    .mem_clken(mem_clken), .mem_readdata(mem_readdata)
  );

  always @(posedge clk) begin
    if (mem_clken && mem_chipselect) begin
      if (mem_write) begin
        ram_tmp = ram[mem_address];
        for (int b = 0; b < 4; b++)
          if (mem_byteenable[b]) ram_tmp[b*8 +: 8] = mem_writedata[b*8 +: 8];
        ram[mem_address] <= ram_tmp;
      end else begin
        mem_readdata <= ram[mem_address];
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic idle();
    m0_read = 1'b0; m0_write = 1'b0; m1_read = 1'b0; m1_write = 1'b0;
  endtask

  initial begin
`ifdef ONCHIP_ARB_FIXED_PRIO_EN
    g = '{0, 0, 0, 0, 0, 0};
`else
    g = '{0, 0, 1, 1, 0, 0};
`endif
    reset_n = 1'b0;
    idle();
    m0_address = '0; m1_address = '0;
    m0_byteenable = 4'hF; m1_byteenable = 4'hF;
    m0_writedata = '0; m1_writedata = '0;

    // Reset: requests are ignored, outputs are in their idle state.
    #3;
    m0_read = 1'b1;
    #1;
    chk("rst_wait0", m0_waitrequest, 1);
    chk("rst_wait1", m1_waitrequest, 1);
    chk("rst_rdv0", m0_readdatavalid, 0);
    chk("rst_rdata0", m0_readdata, 0);
    chk("rst_cs", mem_chipselect, 0);
    chk("rst_clken", mem_clken, 0);
    idle();
    step(); step();
    reset_n = 1'b1;
    #1;
    chk("idle_wait0", m0_waitrequest, 1);
    chk("idle_wait1", m1_waitrequest, 1);
    chk("idle_cs", mem_chipselect, 0);
    chk("idle_clken", mem_clken, 1);

    // m0 write (read also raised: must behave as a write), then read back.
    m0_address = 16'h0010; m0_writedata = 32'hDEADBEEF; m0_byteenable = 4'hF;
    m0_write = 1'b1; m0_read = 1'b1;
    #1;
    chk("wr0_wait0", m0_waitrequest, 0);
    chk("wr0_wait1", m1_waitrequest, 1);
    chk("wr0_cs", mem_chipselect, 1);
    chk("wr0_we", mem_write, 1);
    chk("wr0_addr", mem_address, 32'h10);
    step();
    m0_write = 1'b0;
    #1;
    chk("rd0_wait0", m0_waitrequest, 0);
    chk("rd0_we", mem_write, 0);
    chk("rd0_no_rdv_after_wr", m0_readdatavalid, 0);
    step();
    idle();
    #1;
    chk("rd0_rdv0", m0_readdatavalid, 1);
    chk("rd0_data", m0_readdata, 32'hDEADBEEF);
    chk("rd0_rdv1", m1_readdatavalid, 0);
    step();
    chk("rd0_rdv0_once", m0_readdatavalid, 0);
    chk("rd0_hold", m0_readdata, 32'hDEADBEEF);

    // m1 partial write over a preloaded word.
    m1_address = 16'h0020; m1_writedata = 32'h11223344; m1_byteenable = 4'hF; m1_write = 1'b1;
    #1;
    chk("pre1_wait1", m1_waitrequest, 0);
    chk("pre1_wait0", m0_waitrequest, 1);
    step();
    m1_writedata = 32'h0000AA00; m1_byteenable = 4'h2;
    step();
    m1_write = 1'b0; m1_read = 1'b1;
    step();
    idle();
    #1;
    chk("be1_rdv1", m1_readdatavalid, 1);
    chk("be1_data", m1_readdata, 32'h1122AA44);
    chk("be1_rdv0", m0_readdatavalid, 0);
    chk("be1_hold0", m0_readdata, 32'hDEADBEEF);
    step();

    // Contended back-to-back reads from a fresh reset.
    reset_n = 1'b0;
    #1;
    step();
    reset_n = 1'b1;
    m0_address = 16'h0010; m1_address = 16'h0020;
    for (int i = 0; i < 7; i++) begin
      if (i < 6) begin
        m0_read = 1'b1; m1_read = 1'b1;
      end else begin
        idle();
      end
      #1;
      if (i < 6) begin
        chk($sformatf("str_wait0_%0d", i), m0_waitrequest, 32'(g[i] != 0));
        chk($sformatf("str_wait1_%0d", i), m1_waitrequest, 32'(g[i] != 1));
      end
      if (i > 0) begin
        chk($sformatf("str_rdv0_%0d", i), m0_readdatavalid, 32'(g[i-1] == 0));
        chk($sformatf("str_rdv1_%0d", i), m1_readdatavalid, 32'(g[i-1] == 1));
        if (g[i-1] == 0) chk($sformatf("str_d0_%0d", i), m0_readdata, 32'hDEADBEEF);
        else             chk($sformatf("str_d1_%0d", i), m1_readdata, 32'h1122AA44);
      end
      step();
    end

    // Out-of-range write then read at MEM_WORDS.
    m0_address = 16'd40000; m0_writedata = 32'h12345678; m0_byteenable = 4'hF; m0_write = 1'b1;
    #1;
    chk("oob_wr_wait0", m0_waitrequest, 0);
    chk("oob_wr_cs", mem_chipselect, 0);
    chk("oob_wr_we", mem_write, 0);
    step();
    m0_write = 1'b0; m0_read = 1'b1;
    #1;
    chk("oob_rd_wait0", m0_waitrequest, 0);
    chk("oob_rd_cs", mem_chipselect, 0);
    step();
    idle();
    #1;
    chk("oob_rdv0", m0_readdatavalid, 1);
    chk("oob_data", m0_readdata, 0);
    step();

    // Reset arriving while a read return is in flight.
    m0_address = 16'h0010; m0_read = 1'b1;
    #1;
    chk("mid_wait0", m0_waitrequest, 0);
    step();
    idle();
    chk("mid_pre_rdv0", m0_readdatavalid, 1);
    reset_n = 1'b0;
    #1;
    chk("mid_rst_rdv0", m0_readdatavalid, 0);
    chk("mid_rst_data0", m0_readdata, 0);
    chk("mid_rst_clken", mem_clken, 0);
    step();
    reset_n = 1'b1;
    #1;
    chk("mid_post_rdv0_a", m0_readdatavalid, 0);
    step();
    chk("mid_post_rdv0_b", m0_readdatavalid, 0);
    chk("mid_post_rdv1", m1_readdatavalid, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: observed no finish, expected finish before 20000ns");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/onchip_mem_arbiter.md
Name: onchip_mem_arbiter

Overview:
- Shares one single-port on-chip RAM (32-bit data, 16-bit word address, byte enables, 1-cycle read latency) between two Avalon-MM masters.
- Provides Avalon-MM slave ports with waitrequest and readdatavalid, and drives the RAM's chipselect/write/address/byteenable/clken interface.
- Uses weighted round-robin arbitration, accepts one command per cycle, and supports pipelined back-to-back reads.
- Rejects out-of-range addresses: writes are dropped, reads return zero.

Parameters:
- ADDR_W, 16, word address width.
- DATA_W, 32, data width. Byte-enable width is DATA_W/8.
- MEM_WORDS, 40000, number of implemented words. Addresses >= MEM_WORDS are out of range.
- MAX_GRANT, 2, maximum consecutive grants to one master while the other is requesting. Must be >= 1.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- m0_address  in  ADDR_W  master 0 word address
- m0_byteenable  in  DATA_W/8  master 0 byte enables
- m0_read  in  1  master 0 read request
- m0_write  in  1  master 0 write request
- m0_writedata  in  DATA_W  master 0 write data
- m0_waitrequest  out  1  low = master 0 command accepted this cycle
- m0_readdata  out  DATA_W  master 0 read data
- m0_readdatavalid  out  1  master 0 read data valid
- m1_*  same set as m0_*, for master 1
- mem_address  out  ADDR_W  RAM address
- mem_byteenable  out  DATA_W/8  RAM byte enables
- mem_chipselect  out  1  RAM select
- mem_write  out  1  RAM write strobe
- mem_writedata  out  DATA_W  RAM write data
- mem_clken  out  1  RAM clock enable, tied to 1 when not in reset
- mem_readdata  in  DATA_W  RAM read data, valid the cycle after the address is presented

Behaviour:
Reset (reset_n low, asynchronous):
- mX_waitrequest = 1; mX_readdatavalid = 0; mX_readdata = 0.
- mem_chipselect = 0; mem_write = 0; mem_clken = 0.
- Internal state: owner = 1, count = MAX_GRANT, rd_pend = 0.

Request and grant rules:
- reqX = mX_read | mX_write.
- If read and write are both asserted by one master, the command is treated as a write and produces no readdatavalid.
- Grant is combinational each cycle:
  - Only one master requesting: that master is granted.
  - Both requesting: keep owner if count < MAX_GRANT, otherwise grant the other master.
  - Neither requesting: no grant, and state is unchanged.
- Granted master sees waitrequest = 0 in the same cycle. The non-granted master sees waitrequest = 1.
- On each grant edge:
  - Same master as owner: count <= count + 1, saturating at MAX_GRANT.
  - Different master: owner <= granted master, count <= 1.

Memory interface on a granted cycle:
- mem_address, mem_byteenable, mem_writedata are muxed from the granted master.
- mem_chipselect = 1 and mem_write = the granted master's write, but only if the address is < MAX_WORDS... i.e. < MEM_WORDS. Out-of-range commands are still accepted (waitrequest 0), with mem_chipselect = 0.
- With no grant, mem_chipselect = 0 and mem_write = 0.

Read return:
- A granted read registers rd_pend = 1, rd_owner, and rd_oob.
- The next cycle asserts readdatavalid for rd_owner only.
- readdata = mem_readdata, or 0 if rd_oob. It is registered through for one cycle only; the other master's readdata holds its last value.
- Back-to-back reads: one readdatavalid per accepted read, in order, with 1-cycle latency. There is no stall.

Other cases:
- A write followed by a read to the same address in the next cycle returns the new data.
- reset_n asserted mid-read: the pending readdatavalid is dropped immediately and is not replayed after reset.

Optional Feature:
- Macro: ONCHIP_ARB_FIXED_PRIO_EN.
- Defined: when both masters request, m0 always wins. count and MAX_GRANT are ignored, and m1 may starve.
- Undefined: weighted round-robin as specified above.

Test Plan:
- Hold reset_n low, then release. All waitrequest = 1 and readdatavalid = 0 during reset. First cycle after release with no requests: waitrequest for both = 1, mem_chipselect = 0.
- m0 writes 0xDEADBEEF to 0x0010 with byteenable 0xF, then reads 0x0010. waitrequest = 0 on both cycles. m0_readdatavalid = 1 exactly one cycle after the read, with m0_readdata = 0xDEADBEEF. m1_readdatavalid stays 0.
- Preload 0x0020 = 0x11223344. m1 writes 0x0000AA00 with byteenable 0x2, then reads 0x0020. Returns 0x1122AA44.
- Both masters issue reads continuously from reset, MAX_GRANT = 2. Grant sequence is m0, m0, m1, m1, m0, m0. readdatavalid follows each grant by exactly one cycle with the matching owner.
- m0 writes then reads address 40000 (MEM_WORDS). The write is accepted with mem_chipselect = 0. The read returns m0_readdata = 0 with readdatavalid = 1.
- Assert reset_n in the cycle after a read is accepted. readdatavalid is 0 immediately and no valid is seen after release. Rebuild with ONCHIP_ARB_FIXED_PRIO_EN and both masters requesting: m1 is never granted.
